// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIF FFT.
// Define FFT_SEQ_ABORT_EN to add the abort input.
`timescale 1ns/1ps
module fft_stage_sequencer #(
   parameter int N          = 8,
   parameter int PIPE_DEPTH = 2,
   parameter int LOGN       = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
`ifdef FFT_SEQ_ABORT_EN
   input  logic                    abort,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(LOGN)-1:0] stage,
   output logic [LOGN-1:0]         addr_a,
   output logic [LOGN-1:0]         addr_b,
   output logic [LOGN-2:0]         twiddle_ptr,
   output logic                    busy,
   output logic                    done
);

   localparam int SW = $clog2(LOGN);
   localparam int KW = LOGN - 1;
   localparam int DW = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;
   localparam int DL = (PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0;

   localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DL);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [KW-1:0] k_q, k_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   logic          abort_w;
   logic          hs;
   logic          k_last;
   logic [KW-1:0] mask_k;
   logic [KW-1:0] j_k;
   logic [LOGN-1:0] half;
   logic [LOGN-1:0] a_w;

`ifdef FFT_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign hs     = (state_q == RUN) && out_ready;
   assign k_last = &k_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         stage_q <= '0;
         k_q     <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort_w) begin
               state_d = RUN;
               stage_d = '0;
               k_d     = '0;
            end
         end
         RUN: begin
            if (hs) begin
               k_d = k_q + 1'b1;
               if (k_last) begin
                  k_d = '0;
                  if (PIPE_DEPTH > 0) begin
                     state_d = DRAIN;
                     dcnt_d  = '0;
                  end else if (stage_q == S_LAST) begin
                     state_d = DONE;
                  end else begin
                     stage_d = stage_q + 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == D_LAST) begin
               dcnt_d = '0;
               if (stage_q == S_LAST) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = RUN;
               end
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = '0;
         end
         default: state_d = IDLE;
      endcase
      // a handshake coinciding with abort is simply dropped here
      if (abort_w && (state_q != IDLE)) begin
         state_d = IDLE;
         stage_d = '0;
         k_d     = '0;
         dcnt_d  = '0;
      end
   end

   // a = k with a zero bit inserted at the half position
   always_comb begin
      mask_k = {KW{1'b1}} >> stage_q;
      j_k    = k_q & mask_k;
      half   = {1'b1, {KW{1'b0}}} >> stage_q;
      a_w    = {k_q & ~mask_k, 1'b0} | {1'b0, j_k};
   end

   always_comb begin
      out_valid   = (state_q == RUN);
      busy        = (state_q != IDLE);
      done        = (state_q == DONE) && !abort_w;
      stage       = stage_q;
      addr_a      = a_w;
      addr_b      = a_w + half;
      twiddle_ptr = j_k << stage_q;
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: N=8/PIPE_DEPTH=2 and
// N=16/PIPE_DEPTH=0 instances checked against a division-based golden model.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

   typedef struct {
      int dut;
      int s;
      int a;
      int b;
      int tw;
      int rel;
   } beat_t;

   typedef struct {
      int dut;
      int rel;
   } dn_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic       start0 = 1'b0, rdy0 = 1'b1;
   logic       vld0, busy0, done0;
   logic [1:0] st0;
   logic [2:0] a0, b0;
   logic [1:0] tw0;

   logic       start1 = 1'b0, rdy1 = 1'b1;
   logic       vld1, busy1, done1;
   logic [1:0] st1;
   logic [3:0] a1, b1;
   logic [2:0] tw1;

`ifdef FFT_SEQ_ABORT_EN
   logic abort0 = 1'b0, abort1 = 1'b0;
`endif

   int cyc = 0;
   int t0 = 0;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int last_hs[2];
   beat_t exp_q[$];
   dn_t dn_q[$];

   fft_stage_sequencer #(.N(8), .PIPE_DEPTH(2)) dut0 (
      .clk(clk), .reset(reset), .start(start0),
`ifdef FFT_SEQ_ABORT_EN
      .abort(abort0),
`endif
      .out_valid(vld0), .out_ready(rdy0), .stage(st0),
      .addr_a(a0), .addr_b(b0), .twiddle_ptr(tw0),
      .busy(busy0), .done(done0)
   );

   fft_stage_sequencer #(.N(16), .PIPE_DEPTH(0)) dut1 (
      .clk(clk), .reset(reset), .start(start1),
`ifdef FFT_SEQ_ABORT_EN
      .abort(abort1),
`endif
      .out_valid(vld1), .out_ready(rdy1), .stage(st1),
      .addr_a(a1), .addr_b(b1), .twiddle_ptr(tw1),
      .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic beat_t cur(input int d);
      beat_t r;
      r.dut = d;
      r.rel = 0;
      if (d == 0) begin
         r.s = int'(st0); r.a = int'(a0); r.b = int'(b0); r.tw = int'(tw0);
      end else begin
         r.s = int'(st1); r.a = int'(a1); r.b = int'(b1); r.tw = int'(tw1);
      end
      return r;
   endfunction

   function automatic bit vld_of(input int d);
      return (d == 0) ? vld0 : vld1;
   endfunction

   function automatic bit rdy_of(input int d);
      return (d == 0) ? rdy0 : rdy1;
   endfunction

   function automatic bit dn_of(input int d);
      return (d == 0) ? done0 : done1;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic monitor();
      beat_t held[2];
      bit stall[2];
      beat_t c, e;
      dn_t x;
      int rel, want;
      stall[0] = 1'b0;
      stall[1] = 1'b0;
      forever begin
         @(negedge clk);
         rel = cyc - t0 + 1;
         for (int d = 0; d < 2; d++) begin
            c = cur(d);
            if (stall[d]) begin
               checks++;
               if (!vld_of(d) || c.s != held[d].s || c.a != held[d].a ||
                   c.b != held[d].b || c.tw != held[d].tw) begin
                  failures++;
                  $display("FAIL hold dut%0d rel=%0d actual v=%0d a/b/tw=%0d/%0d/%0d expected v=1 a/b/tw=%0d/%0d/%0d",
                           d, rel, vld_of(d), c.a, c.b, c.tw, held[d].a, held[d].b, held[d].tw);
               end
            end
            stall[d] = vld_of(d) && !rdy_of(d) && reset;
            held[d] = c;
            if (vld_of(d) && rdy_of(d)) begin
               checks++;
               last_hs[d] = rel;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL beat dut%0d rel=%0d actual=unexpected beat expected=none", d, rel);
               end else begin
                  e = exp_q.pop_front();
                  if (e.dut != d || e.s != c.s || e.a != c.a || e.b != c.b ||
                      e.tw != c.tw || (e.rel >= 0 && e.rel != rel)) begin
                     failures++;
                     $display("FAIL beat dut%0d actual s/a/b/tw=%0d/%0d/%0d/%0d@%0d expected dut%0d %0d/%0d/%0d/%0d@%0d",
                              d, c.s, c.a, c.b, c.tw, rel, e.dut, e.s, e.a, e.b, e.tw, e.rel);
                  end
               end
            end
            if (dn_of(d)) begin
               checks++;
               done_cnt++;
               if (dn_q.size() == 0) begin
                  failures++;
                  $display("FAIL done dut%0d actual=unexpected pulse@%0d expected=none", d, rel);
               end else begin
                  x = dn_q.pop_front();
                  want = (x.rel >= 0) ? x.rel : last_hs[d] + ((d == 0) ? 2 : 0) + 1;
                  if (x.dut != d || want != rel) begin
                     failures++;
                     $display("FAIL done dut%0d actual=@%0d expected=dut%0d@%0d", d, rel, x.dut, want);
                  end
               end
            end
         end
      end
   endtask

   task automatic push_pass(input int d, input int n, input int p,
                            input int base, input bit timed, input int lim);
      int lg, cnt, half, g, j;
      beat_t e;
      dn_t x;
      lg = $clog2(n);
      cnt = 0;
      for (int s = 0; s < lg; s++) begin
         for (int k = 0; k < n / 2; k++) begin
            half = n >> (s + 1);
            g = k / half;
            j = k % half;
            e.dut = d;
            e.s = s;
            e.a = g * 2 * half + j;
            e.b = e.a + half;
            e.tw = (j << s) % (n / 2);
            e.rel = timed ? base + s * (n / 2 + p) + k + 1 : -1;
            if (cnt < lim) exp_q.push_back(e);
            cnt++;
         end
      end
      if (lim >= lg * n / 2) begin
         x.dut = d;
         x.rel = timed ? base + lg * (n / 2 + p) + 1 : -1;
         dn_q.push_back(x);
      end
   endtask

   task automatic do_start(input int d);
      @(posedge clk);
      #2;
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int c0, n;
      c0 = done_cnt;
      n = 0;
      while (done_cnt == c0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (done_cnt == c0) begin
         failures++;
         $display("FAIL done_timeout actual=no pulse expected=pulse within %0d cycles", bound);
      end
   endtask

   task automatic drained(input string nm);
      repeat (3) @(posedge clk);
      #2;
      chk({nm, "_beats_left"}, exp_q.size(), 0);
      chk({nm, "_dones_left"}, dn_q.size(), 0);
      chk({nm, "_busy_after"}, int'(busy0 | busy1), 0);
   endtask

   initial begin
      int c0, n;
      last_hs[0] = 0;
      last_hs[1] = 0;
      fork
         monitor();
      join_none

      #3;
      chk("rst_valid", int'(vld0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_addr_a", int'(a0), 0);
      chk("rst_addr_b", int'(b0), 4);
      chk("rst_stage", int'(st0), 0);
      chk("rst_tw", int'(tw0), 0);
      chk("rst_addr_b16", int'(b1), 8);
      #14 reset = 1'b1;

      // golden sequence, plus a start pulse mid-pass that must be ignored
      push_pass(0, 8, 2, 0, 1, 1000);
      do_start(0);
      #1 chk("busy_first_cycle", int'(busy0), 1);
      repeat (7) @(posedge clk);
      #2 start0 = 1'b1;
      @(posedge clk);
      #2 start0 = 1'b0;
      wait_done(60);
      drained("golden");

      // backpressure
      push_pass(0, 8, 2, 0, 0, 1000);
      do_start(0);
      c0 = done_cnt;
      n = 0;
      while (done_cnt == c0 && n < 400) begin
         @(posedge clk);
         #2 rdy0 = ($urandom_range(0, 2) != 0);
         n++;
      end
      rdy0 = 1'b1;
      checks++;
      if (done_cnt == c0) begin
         failures++;
         $display("FAIL bp_timeout actual=no done expected=done within 400 cycles");
      end
      drained("backpressure");

      // start held high for 40 cycles: two passes, 20 cycles apart
      push_pass(0, 8, 2, 0, 1, 1000);
      push_pass(0, 8, 2, 20, 1, 1000);
      c0 = done_cnt;
      @(posedge clk);
      #2 start0 = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      repeat (39) @(posedge clk);
      #1 start0 = 1'b0;
      repeat (5) @(posedge clk);
      chk("held_start_dones", done_cnt - c0, 2);
      drained("held_start");

      // asynchronous reset in the middle of stage 0
      push_pass(0, 8, 2, 0, 1, 1000);
      do_start(0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_valid", int'(vld0), 0);
      chk("midrst_busy", int'(busy0), 0);
      chk("midrst_addr_a", int'(a0), 0);
      chk("midrst_addr_b", int'(b0), 4);
      chk("midrst_stage", int'(st0), 0);
      exp_q.delete();
      dn_q.delete();
      c0 = done_cnt;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (12) @(posedge clk);
      #2;
      chk("postrst_valid", int'(vld0), 0);
      chk("postrst_busy", int'(busy0), 0);
      chk("postrst_dones", done_cnt - c0, 0);

      // N=16, no drain gap
      push_pass(1, 16, 0, 0, 1, 1000);
      do_start(1);
      wait_done(60);
      drained("n16_nodrain");

`ifdef FFT_SEQ_ABORT_EN
      push_pass(0, 8, 2, 0, 1, 6);
      c0 = done_cnt;
      do_start(0);
      repeat (7) @(posedge clk);
      #2 abort0 = 1'b1;
      @(posedge clk);
      #2 abort0 = 1'b0;
      #1;
      chk("abort_busy", int'(busy0), 0);
      chk("abort_valid", int'(vld0), 0);
      chk("abort_stage", int'(st0), 0);
      repeat (10) @(posedge clk);
      chk("abort_no_done", done_cnt - c0, 0);
      chk("abort_beats_left", exp_q.size(), 0);
      #2 start0 = 1'b1;
      abort0 = 1'b1;
      @(posedge clk);
      #2 start0 = 1'b0;
      abort0 = 1'b0;
      #1 chk("abort_beats_start", int'(busy0), 0);
      push_pass(0, 8, 2, 0, 1, 1000);
      do_start(0);
      wait_done(60);
      drained("after_abort");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
